// File: rtl/spike_event_logger.sv
// Spike detector that follows the Izhikevich core. It applies a refractory gate, timestamps
// each accepted spike with the step count, and queues the timestamps in a first-word
// fall-through FIFO.
module spike_event_logger #(
  parameter int N     = 32,
  parameter int T     = 16,
  parameter int DEPTH = 8,
  parameter int R     = 8,
  parameter int C     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     apply,
  input  logic [N-1:0]             voltage,
  input  logic [N-1:0]             v_th,
  input  logic [R-1:0]             refrac,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [T-1:0]             out_time,
  output logic                     spike,
  output logic [C-1:0]             spike_count,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic {ARMED, REFRAC} state_t;

  state_t         state_q, state_d;
  logic [R-1:0]   rcnt_q, rcnt_d;
  logic [T-1:0]   step_q, step_d;
  logic           spike_q, spike_d;
  logic [C-1:0]   count_q, count_d;
  logic           overflow_q, overflow_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_next;
  logic [LW-1:0]  level_q, level_d;
  logic [T-1:0]   head_q, head_d;
  logic [T-1:0]   mem [DEPTH];

  logic crossing, accept, pop, push_ok;

  // Same strict compare the core uses to reload v to c.
  assign crossing = apply && ($signed(voltage) > $signed(v_th));

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    step_d  = step_q;
    accept  = 1'b0;
    if (apply) begin
      step_d = step_q + T'(1);
      case (state_q)
        ARMED: begin
          if (crossing) begin
            accept = 1'b1;
            if (refrac != '0) begin
              state_d = REFRAC;
              rcnt_d  = refrac;
            end
          end
        end
        REFRAC: begin
          rcnt_d = rcnt_q - R'(1);
          if (rcnt_q == R'(1)) state_d = ARMED;
        end
        default: state_d = ARMED;
      endcase
    end
  end

  // The head register mirrors mem[rd_ptr], so out_time never changes while it is stalled.
  always_comb begin
    pop        = (level_q != '0) && out_ready;
    push_ok    = accept && ((level_q != LW'(DEPTH)) || pop);
    overflow_d = overflow_q | (accept && !push_ok);
    spike_d    = accept;
    count_d    = (accept && count_q != '1) ? count_q + C'(1) : count_q;
    level_d    = level_q + LW'(push_ok) - LW'(pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    rd_next    = rd_ptr_q + AW'(1);
    head_d     = head_q;
    if (push_ok && (level_q == '0 || (pop && level_q == LW'(1))))
      head_d = step_q;
    else if (pop && level_q > LW'(1))
      head_d = mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ARMED;
      rcnt_q     <= '0;
      step_q     <= '0;
      spike_q    <= 1'b0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      head_q     <= '0;
    end else begin
      state_q    <= state_d;
      rcnt_q     <= rcnt_d;
      step_q     <= step_d;
      spike_q    <= spike_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      head_q     <= head_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !rst) mem[wr_ptr_q] <= step_q;
  end

  assign out_valid   = (level_q != '0);
  assign out_time    = head_q;
  assign spike       = spike_q;
  assign spike_count = count_q;
  assign overflow    = overflow_q;
  assign fifo_level  = level_q;

endmodule

// File: tb/tb_spike_event_logger.sv
// Directed bench for spike_event_logger, with a second instance (T=4) for timestamp wrap.
module tb_spike_event_logger;

  logic        clk = 1'b0;
  logic        rst;
  logic        apply;
  logic [31:0] voltage;
  logic [31:0] v_th;
  logic [7:0]  refrac;
  logic        out_ready, out_ready4;

  logic        out_valid, spike, overflow;
  logic [15:0] out_time, spike_count;
  logic [3:0]  fifo_level;

  logic        out_valid4, spike4, overflow4;
  logic [3:0]  out_time4, fifo_level4;
  logic [15:0] spike_count4;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [31:0] VTH  = 32'h001E_0000;
  localparam logic [31:0] HIGH = 32'h001E_0001;
  localparam logic [31:0] LOW  = 32'h0000_0000;

  always #5 clk = ~clk;

  spike_event_logger #(.N(32), .T(16), .DEPTH(8), .R(8), .C(16)) u_dut (
    .clk(clk), .rst(rst), .apply(apply), .voltage(voltage), .v_th(v_th),
    .refrac(refrac), .out_ready(out_ready), .out_valid(out_valid),
    .out_time(out_time), .spike(spike), .spike_count(spike_count),
    .overflow(overflow), .fifo_level(fifo_level)
  );

  spike_event_logger #(.N(32), .T(4), .DEPTH(8), .R(8), .C(16)) u_dut4 (
    .clk(clk), .rst(rst), .apply(apply), .voltage(voltage), .v_th(v_th),
    .refrac(refrac), .out_ready(out_ready4), .out_valid(out_valid4),
    .out_time(out_time4), .spike(spike4), .spike_count(spike_count4),
    .overflow(overflow4), .fifo_level(fifo_level4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; apply = 1'b0; out_ready = 1'b0; out_ready4 = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_apply(input logic [31:0] v);
    apply = 1'b1; voltage = v;
    tick();
    apply = 1'b0;
  endtask

  // Check the head, then pop it on the next edge.
  task automatic pop_expect(input string tag, input logic [15:0] t);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_time"}, 32'(out_time), 32'(t));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; apply = 1'b0; voltage = LOW; v_th = VTH; refrac = 8'd0;
    out_ready = 1'b0; out_ready4 = 1'b0;
    tick();

    // 1: equality is not a spike; strict crossing is
    do_reset();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_time", 32'(out_time), 32'd0);
    chk("rst_spike", 32'(spike), 32'd0);
    chk("rst_count", 32'(spike_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_level", 32'(fifo_level), 32'd0);
    do_apply(VTH);
    chk("t1_eq_spike", 32'(spike), 32'd0);
    chk("t1_eq_valid", 32'(out_valid), 32'd0);
    do_apply(HIGH);
    chk("t1_spike", 32'(spike), 32'd1);
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_time", 32'(out_time), 32'd1);
    chk("t1_count", 32'(spike_count), 32'd1);
    tick();
    chk("t1_pulse_end", 32'(spike), 32'd0);
    chk("t1_hold_time", 32'(out_time), 32'd1);

    // 2: refractory window of 3 -> accepted at 0, 4, 8
    do_reset();
    refrac = 8'd3;
    for (int s = 0; s < 10; s++) begin
      do_apply(HIGH);
      chk($sformatf("t2_spike_s%0d", s), 32'(spike), 32'((s % 4) == 0));
    end
    chk("t2_count", 32'(spike_count), 32'd3);
    chk("t2_level", 32'(fifo_level), 32'd3);
    pop_expect("t2_pop0", 16'd0);
    pop_expect("t2_pop1", 16'd4);
    pop_expect("t2_pop2", 16'd8);
    chk("t2_empty", 32'(out_valid), 32'd0);
    chk("t2_hold_time", 32'(out_time), 32'd8);

    // 3: overflow when full without readout
    do_reset();
    refrac = 8'd0;
    for (int s = 0; s < 10; s++) do_apply(HIGH);
    chk("t3_level", 32'(fifo_level), 32'd8);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_count", 32'(spike_count), 32'd10);
    for (int s = 0; s < 8; s++) pop_expect($sformatf("t3_pop%0d", s), 16'(s));
    chk("t3_empty", 32'(out_valid), 32'd0);
    chk("t3_level0", 32'(fifo_level), 32'd0);
    chk("t3_ovf_sticky", 32'(overflow), 32'd1);

    // 4: full + push + pop in the same cycle
    do_reset();
    for (int s = 0; s < 8; s++) do_apply(HIGH);
    chk("t4_full", 32'(fifo_level), 32'd8);
    out_ready = 1'b1;
    do_apply(HIGH);
    out_ready = 1'b0;
    chk("t4_level", 32'(fifo_level), 32'd8);
    chk("t4_ovf", 32'(overflow), 32'd0);
    for (int s = 1; s <= 8; s++) pop_expect($sformatf("t4_pop%0d", s), 16'(s));
    chk("t4_empty", 32'(out_valid), 32'd0);

    // 5: 4-bit timestamps wrap 15 -> 0
    do_reset();
    for (int s = 0; s < 18; s++) do_apply((s == 15 || s == 16) ? HIGH : LOW);
    chk("t5_level", 32'(fifo_level4), 32'd2);
    chk("t5_head0", 32'(out_time4), 32'd15);
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    chk("t5_valid1", 32'(out_valid4), 32'd1);
    chk("t5_head1", 32'(out_time4), 32'd0);

    // 6: reset mid-REFRAC with entries queued and a crossing present
    do_reset();
    refrac = 8'd0;
    do_apply(HIGH);
    do_apply(HIGH);
    refrac = 8'd5;
    do_apply(HIGH);
    do_apply(HIGH);
    chk("t6_level", 32'(fifo_level), 32'd3);
    chk("t6_blocked", 32'(spike), 32'd0);
    rst = 1'b1; apply = 1'b1; voltage = HIGH;
    tick();
    rst = 1'b0; apply = 1'b0;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_time", 32'(out_time), 32'd0);
    chk("t6_spike", 32'(spike), 32'd0);
    chk("t6_count", 32'(spike_count), 32'd0);
    chk("t6_level0", 32'(fifo_level), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd0);
    do_apply(HIGH);
    chk("t6_armed_spike", 32'(spike), 32'd1);
    chk("t6_armed_valid", 32'(out_valid), 32'd1);
    chk("t6_armed_time", 32'(out_time), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
